vga_timing_gen: RTL and testbench

Parametrised VGA timing and pattern generator; the next-generation replacement for the fixed 640x480 white-fill VGA block. It derives a pixel-rate enable from the system clock, runs programmable horizontal/vertical counters, and emits sync, data-enable, pixel coordinates, frame/line strobes and 4-bit-per-channel colour. It sits between the system clock domain and the board VGA connector. The colour source is either a built-in test pattern or an external 12-bit pixel input.

---
 rtl/vga_timing_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Pixel-side bundle of the VGA timing generator: pattern controls in,
// sync/enable/coordinate/colour out.
// Contract: there is no backpressure. Every output is a register that
// changes only on a clk edge where pix_ce is high. frame_start and
// line_start are the exception: they are one clk wide.
interface vga_timing_if #(
  parameter int CW = 12
);
  logic [1:0]    mode;
  logic [11:0]   rgb_in;
  logic          pix_ce;
  logic          Hsynq;
  logic          Vsynq;
  logic          de;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_start;
  logic          line_start;
  logic [3:0]    Red;
  logic [3:0]    Green;
  logic [3:0]    Blue;

  // Generator side
  modport master (
    input  mode, rgb_in,
    output pix_ce, Hsynq, Vsynq, de, pixel_x, pixel_y,
           frame_start, line_start, Red, Green, Blue
  );

  // Display / consumer side
  modport slave (
    output mode, rgb_in,
    input  pix_ce, Hsynq, Vsynq, de, pixel_x, pixel_y,
           frame_start, line_start, Red, Green, Blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator.
// The clock divider produces a one-clk tick every CLK_DIV clocks. The h/v
// counters advance on that tick. All outputs are registered from the
// pre-increment counter values on the same tick, so they stay coherent for
// one (h,v) pair. The CW parameter must match the interface instance and
// must hold H_TOTAL-1 and V_TOTAL-1.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input logic        clk,
  input logic        rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q;
  logic          tick;

  logic          pix_ce_q;
  logic          hs_q, vs_q, de_q;
  logic [CW-1:0] px_q, py_q;
  logic          frame_q, line_q;
  logic [11:0]   rgb_q;

  logic          de_d, hs_d, vs_d, frame_d, line_d;
  logic [1:0]    mode_eff;
  logic [2:0]    bar;
  logic [4:0]    h_lo, v_lo;
  logic [11:0]   rgb_d;

  assign tick = (div_cnt_q == DIV_LAST);

  // Divider and raster counters: next-state values
  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Decode of the current (pre-increment) counter position
  always_comb begin
    de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_d    = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    line_d  = (h_cnt_q == '0);
    frame_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    // The first pixel of a frame already uses the newly sampled mode
    mode_eff = frame_d ? vga.mode : mode_q;
    // Bar index via a compare chain, so no divider is built
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= CW'(i * BAR_W)) bar = 3'(i);
    end
    h_lo  = 5'(h_cnt_q);
    v_lo  = 5'(v_cnt_q);
    rgb_d = 12'h000;
    if (de_d) begin
      case (mode_eff)
        2'd0: rgb_d = 12'hFFF;
        2'd1: rgb_d = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        2'd2: rgb_d = ((h_lo == 5'd0) || (v_lo == 5'd0) ||
                       (h_cnt_q == H_ACT_LAST) || (v_cnt_q == V_ACT_LAST))
                      ? 12'hFFF : 12'h000;
        default: rgb_d = vga.rgb_in;
      endcase
    end
  end

  // Counter state and the mode latch taken at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      mode_q    <= 2'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      if (tick && frame_d) mode_q <= vga.mode;
    end
  end

  // Output registers: load on the tick, strobes drop on the following clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_ce_q <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      de_q     <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      pix_ce_q <= tick;
      frame_q  <= tick & frame_d;
      line_q   <= tick & line_d;
      if (tick) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        de_q  <= de_d;
        px_q  <= h_cnt_q;
        py_q  <= v_cnt_q;
        rgb_q <= rgb_d;
      end
    end
  end

  assign vga.pix_ce      = pix_ce_q;
  assign vga.Hsynq       = hs_q;
  assign vga.Vsynq       = vs_q;
  assign vga.de          = de_q;
  assign vga.pixel_x     = px_q;
  assign vga.pixel_y     = py_q;
  assign vga.frame_start = frame_q;
  assign vga.line_start  = line_q;
  assign vga.Red         = rgb_q[11:8];
  assign vga.Green       = rgb_q[7:4];
  assign vga.Blue        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a reduced
// geometry that makes whole frames affordable, and a tiny CLK_DIV=1 set.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_def, rst_med, rst_sml;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.CW(12)) def_if ();
  vga_timing_if #(.CW(8))  med_if ();
  vga_timing_if #(.CW(4))  sml_if ();

  vga_timing_gen u_def (.clk(clk), .rst(rst_def), .vga(def_if));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .CW(8)
  ) u_med (.clk(clk), .rst(rst_med), .vga(med_if));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .CW(4)
  ) u_sml (.clk(clk), .rst(rst_sml), .vga(sml_if));

  logic [11:0] def_rgb, med_rgb, sml_rgb;
  assign def_rgb = {def_if.Red, def_if.Green, def_if.Blue};
  assign med_rgb = {med_if.Red, med_if.Green, med_if.Blue};
  assign sml_rgb = {sml_if.Red, sml_if.Green, sml_if.Blue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick_def();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!def_if.pix_ce && n < 64);
    if (!def_if.pix_ce) check("def_tick_timeout", 32'd1, 32'd0);
  endtask

  task automatic tick_med();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!med_if.pix_ce && n < 64);
    if (!med_if.pix_ce) check("med_tick_timeout", 32'd1, 32'd0);
  endtask

  task automatic tick_sml();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!sml_if.pix_ce && n < 64);
    if (!sml_if.pix_ce) check("sml_tick_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n, ticks, de_n, hs_n, hs_first, lines, vs_n, vs_first, bad, bad_de;
    logic [11:0] c79, c80, c639, c640, exp_c;
    logic exp_de;

    rst_def = 1'b1; rst_med = 1'b1; rst_sml = 1'b1;
    def_if.mode = 2'd1; def_if.rgb_in = 12'h000;
    med_if.mode = 2'd0; med_if.rgb_in = 12'h5A3;
    sml_if.mode = 2'd0; sml_if.rgb_in = 12'h000;

    // ---------------- default timing ----------------
    repeat (3) @(posedge clk);
    #1;
    check("def_rst_hs", def_if.Hsynq, 1);
    check("def_rst_vs", def_if.Vsynq, 1);
    check("def_rst_pix_ce", def_if.pix_ce, 0);
    check("def_rst_de", def_if.de, 0);
    check("def_rst_rgb", def_rgb, 0);
    check("def_rst_xy", {def_if.pixel_x, def_if.pixel_y}, 0);

    @(negedge clk); rst_def = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!def_if.frame_start && n < 20);
    check("def_first_fs_clks", n, 4);
    check("def_first_pix_ce", def_if.pix_ce, 1);
    check("def_first_ls", def_if.line_start, 1);
    check("def_first_xy", {def_if.pixel_x, def_if.pixel_y}, 0);
    check("def_first_de", def_if.de, 1);
    check("def_first_bar0", def_rgb, 12'h000);

    @(posedge clk); #1;
    check("def_pix_ce_width", def_if.pix_ce, 0);
    check("def_fs_width", def_if.frame_start, 0);
    check("def_ls_width", def_if.line_start, 0);
    check("def_hold_de", def_if.de, 1);
    check("def_hold_x", def_if.pixel_x, 0);
    n = 1;
    while (!def_if.pix_ce && n < 20) begin @(posedge clk); #1; n++; end
    check("def_pix_ce_period", n, 4);
    check("def_second_x", def_if.pixel_x, 1);

    // advance to the start of line 1, then measure that whole line
    n = 0;
    do begin tick_def(); n++; end while (!def_if.line_start && n < 1000);
    check("def_line1_y", def_if.pixel_y, 1);
    ticks = 0; de_n = 0; hs_n = 0; hs_first = -1;
    c79 = 'x; c80 = 'x; c639 = 'x; c640 = 'x;
    do begin
      if (def_if.de) de_n++;
      if (!def_if.Hsynq) begin
        if (hs_n == 0) hs_first = int'(def_if.pixel_x);
        hs_n++;
      end
      if (def_if.pixel_x == 12'd79)  c79  = def_rgb;
      if (def_if.pixel_x == 12'd80)  c80  = def_rgb;
      if (def_if.pixel_x == 12'd639) c639 = def_rgb;
      if (def_if.pixel_x == 12'd640) c640 = def_rgb;
      tick_def(); ticks++;
    end while (!def_if.line_start && ticks < 2000);
    check("def_line_ticks", ticks, 800);
    check("def_de_ticks", de_n, 640);
    check("def_hs_ticks", hs_n, 96);
    check("def_hs_first_x", hs_first, 656);
    check("def_bar_x79", c79, 12'h000);
    check("def_bar_x80", c80, 12'h00F);
    check("def_bar_x639", c639, 12'hFFF);
    check("def_blank_x640", c640, 12'h000);
    check("def_next_line_y", def_if.pixel_y, 2);

    // async reset mid-frame, restart in grid mode
    #2; def_if.mode = 2'd2; rst_def = 1'b1;
    #1;
    check("def_async_de", def_if.de, 0);
    check("def_async_xy", {def_if.pixel_x, def_if.pixel_y}, 0);
    @(negedge clk); rst_def = 1'b0;
    n = 0;
    while (!(def_if.pixel_y == 12'd5 && def_if.pixel_x == 12'd32) && n < 6000) begin
      tick_def(); n++;
    end
    check("def_grid_32_5", def_rgb, 12'hFFF);
    tick_def();
    check("def_grid_33_5_x", def_if.pixel_x, 33);
    check("def_grid_33_5", def_rgb, 12'h000);
    n = 0;
    while (def_if.pixel_x != 12'd638 && n < 1000) begin tick_def(); n++; end
    check("def_grid_638_5", def_rgb, 12'h000);
    tick_def();
    check("def_grid_639_5", def_rgb, 12'hFFF);

    // ---------------- reduced geometry: frames and mode latch ----------------
    @(negedge clk); rst_med = 1'b0;
    n = 0;
    do begin tick_med(); n++; end while (!med_if.frame_start && n < 100);
    check("med_first_fs", med_if.frame_start, 1);
    ticks = 0; lines = 0; vs_n = 0; vs_first = -1; bad = 0; bad_de = 0;
    do begin
      if (med_if.line_start) begin
        lines++;
        if (!med_if.Vsynq) begin
          if (vs_n == 0) vs_first = int'(med_if.pixel_y);
          vs_n++;
        end
        if (med_if.pixel_y == 8'd3) med_if.mode = 2'd3;
      end
      exp_de = (med_if.pixel_x < 8'd16) && (med_if.pixel_y < 8'd10);
      if (med_if.de !== exp_de) bad_de++;
      exp_c = exp_de ? 12'hFFF : 12'h000;
      if (med_rgb !== exp_c) bad++;
      tick_med(); ticks++;
    end while (!med_if.frame_start && ticks < 1000);
    check("med_frame_ticks", ticks, 408);
    check("med_frame_lines", lines, 17);
    check("med_vs_lines", vs_n, 2);
    check("med_vs_first_y", vs_first, 12);
    check("med_de_f1", bad_de, 0);
    check("med_hold_white", bad, 0);
    check("med_fs_rgb", med_rgb, 12'h5A3);

    ticks = 0; de_n = 0; bad = 0;
    do begin
      exp_de = (med_if.pixel_x < 8'd16) && (med_if.pixel_y < 8'd10);
      if (exp_de) de_n++;
      exp_c = exp_de ? 12'h5A3 : 12'h000;
      if (med_rgb !== exp_c) bad++;
      tick_med(); ticks++;
    end while (!med_if.frame_start && ticks < 1000);
    check("med_frame2_ticks", ticks, 408);
    check("med_ext_rgb", bad, 0);
    check("med_active_pixels", de_n, 160);

    // ---------------- tiny params, CLK_DIV=1, HS_POL=1 ----------------
    #1;
    check("sml_rst_hs", sml_if.Hsynq, 0);
    check("sml_rst_vs", sml_if.Vsynq, 1);
    @(negedge clk); rst_sml = 1'b0;
    @(posedge clk); #1;
    check("sml_first_pix_ce", sml_if.pix_ce, 1);
    check("sml_first_fs", sml_if.frame_start, 1);
    @(posedge clk); #1;
    check("sml_pix_ce_const", sml_if.pix_ce, 1);
    check("sml_fs_width", sml_if.frame_start, 0);
    check("sml_x1", sml_if.pixel_x, 1);
    n = 0;
    do begin tick_sml(); n++; end while (!sml_if.line_start && n < 100);
    check("sml_line_after", n, 11);
    ticks = 0; hs_n = 0; hs_first = -1;
    do begin
      if (sml_if.Hsynq) begin
        if (hs_n == 0) hs_first = int'(sml_if.pixel_x);
        hs_n++;
      end
      tick_sml(); ticks++;
    end while (!sml_if.line_start && ticks < 100);
    check("sml_line_ticks", ticks, 12);
    check("sml_hs_ticks", hs_n, 2);
    check("sml_hs_first_x", hs_first, 9);
    repeat (5) tick_sml();
    check("sml_x5", sml_if.pixel_x, 5);
    check("sml_x5_de", sml_if.de, 1);
    check("sml_x5_rgb", sml_rgb, 12'hFFF);
    #2; rst_sml = 1'b1;
    #1;
    check("sml_async_xy", {sml_if.pixel_x, sml_if.pixel_y}, 0);
    check("sml_async_de", sml_if.de, 0);
    check("sml_async_hs", sml_if.Hsynq, 0);
    check("sml_async_pix_ce", sml_if.pix_ce, 0);
    check("sml_async_rgb", sml_rgb, 0);
    @(negedge clk); rst_sml = 1'b0;
    @(posedge clk); #1;
    check("sml_restart_xy", {sml_if.pixel_x, sml_if.pixel_y}, 0);
    check("sml_restart_fs", sml_if.frame_start, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
